// File: rtl/draw_sprite.sv
// rtl/draw_sprite.sv - ROM-backed rectangular sprite overlay stage for a VGA pixel stream
//
// Overlays a SPRITE_W x SPRITE_H bitmap, read from an external synchronous ROM,
// onto the incoming pixel stream. The position, mirror and enable inputs are
// shadowed on the rising edge of in_vblnk, so a frame is always drawn with one
// consistent set of values. All in_* fields reach out_* after ROM_LATENCY+1 clocks.
//
// Optional feature: define DRAW_SPRITE_TRANSPARENCY_EN to let ROM pixels equal
// to KEY_RGB show the background instead of the sprite.
//
// Ports:
//   clk, rst               pixel clock, synchronous active-high reset
//   xpos, ypos             requested sprite left edge / top edge
//   mirror, enable         horizontal flip, sprite visible
//   rgb_pixel              ROM data for pixel_addr presented ROM_LATENCY clocks earlier
//   pixel_addr             ROM address, combinational from in_* and shadow state
//   in_hcount .. in_rgb    upstream timing and colour
//   out_hcount .. out_rgb  downstream timing and colour
module draw_sprite #(
  parameter int          SPRITE_W    = 64,
  parameter int          SPRITE_H    = 64,
  parameter int          ROM_LATENCY = 1,
  parameter logic [11:0] KEY_RGB     = 12'hF0F,
  parameter int          ADDR_W      = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              mirror,
  input  logic              enable,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       in_hcount,
  input  logic [11:0]       in_vcount,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_hblnk,
  input  logic              in_vblnk,
  input  logic [11:0]       in_rgb,
  output logic [11:0]       out_hcount,
  output logic [11:0]       out_vcount,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_hblnk,
  output logic              out_vblnk,
  output logic [11:0]       out_rgb
);

  localparam int XW    = $clog2(SPRITE_W);
  localparam int YW    = $clog2(SPRITE_H);
  localparam int RGB_W = $bits(KEY_RGB);

  typedef struct packed {
    logic [11:0]      hcount;
    logic [11:0]      vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
    logic             hit;
  } line_t;

  // Frame shadow state
  logic [11:0] x_l;
  logic [11:0] y_l;
  logic        mir_l;
  logic        en_l;
  logic        vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_l     <= '0;
      y_l     <= '0;
      mir_l   <= 1'b0;
      en_l    <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= in_vblnk;
      if (in_vblnk && !vblnk_d) begin
        x_l   <= xpos;
        y_l   <= ypos;
        mir_l <= mirror;
        en_l  <= enable;
      end
    end
  end

  // Hit test; the far edges are 13 bits so a sprite hanging past 4095 never wraps to 0.
  logic [12:0]   x_end;
  logic [12:0]   y_end;
  logic          hit;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [XW-1:0] cx;

  assign x_end = {1'b0, x_l} + 13'(SPRITE_W);
  assign y_end = {1'b0, y_l} + 13'(SPRITE_H);

  assign hit = en_l & ~in_hblnk & ~in_vblnk
             & (in_hcount >= x_l) & ({1'b0, in_hcount} < x_end)
             & (in_vcount >= y_l) & ({1'b0, in_vcount} < y_end);

  // Offsets only matter modulo the sprite size, so subtract the truncated operands.
  assign dx = in_hcount[XW-1:0] - x_l[XW-1:0];
  assign dy = in_vcount[YW-1:0] - y_l[YW-1:0];
  // SPRITE_W is a power of two, so SPRITE_W-1-dx is the bitwise complement of dx.
  assign cx = mir_l ? ~dx : dx;

  assign pixel_addr = hit ? {dy, cx} : '0;

  // Delay line aligning the stream with the ROM data
  line_t dly [ROM_LATENCY];
  line_t tail;
  logic  sel;

  assign tail = dly[ROM_LATENCY-1];

`ifdef DRAW_SPRITE_TRANSPARENCY_EN
  assign sel = tail.hit & (rgb_pixel != KEY_RGB);
`else
  assign sel = tail.hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) dly[i] <= '0;
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
    end else begin
      dly[0] <= {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb, hit};
      for (int i = 1; i < ROM_LATENCY; i++) dly[i] <= dly[i-1];
      out_hcount <= tail.hcount;
      out_vcount <= tail.vcount;
      out_hsync  <= tail.hsync;
      out_vsync  <= tail.vsync;
      out_hblnk  <= tail.hblnk;
      out_vblnk  <= tail.vblnk;
      out_rgb    <= sel ? rgb_pixel : tail.rgb;
    end
  end

endmodule
